// File: rtl/fifo_pkg.sv
// Geometry constants shared by the write-side control, read-side control
// and the gray encoder of the dual-clock FIFO.
package fifo_pkg;
    localparam int FIFO_ADDR_W = 2;
    localparam int FIFO_PW     = FIFO_ADDR_W + 1;
    localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a gray-coded pointer crossing into the local clock.
module sync_2ff #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q1;
    logic [W-1:0] r_q2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO control: binary write pointer, read-pointer synchronisation,
// full / almost-full / level derivation and a sticky overflow flag.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = FIFO_ADDR_W,
    parameter int AF_LEVEL = 3
) (
    input  logic              clk_en,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W:0]   wr_ptr_bin,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_mem_en,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);

    logic [PW-1:0] r_wr_ptr;
    logic          r_overflow;
    logic [PW-1:0] w_rq2;
    logic [PW-1:0] w_rd_bin;
    logic [PW-1:0] w_level;
    logic          w_full;
    logic          w_accept;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    sync_2ff #(.W(PW)) u_rd_sync (
        .i_clk   (clk_en),
        .i_rst_n (rst_n),
        .i_d     (rd_ptr_gray),
        .o_q     (w_rq2)
    );

    // The synchronised read pointer is only ever stale, so level and full
    // err on the side of reporting more occupancy than is real.
    assign w_rd_bin = gray2bin(w_rq2);
    assign w_level  = r_wr_ptr - w_rd_bin;
    assign w_full   = (r_wr_ptr[PW-1] != w_rd_bin[PW-1]) &&
                      (r_wr_ptr[PW-2:0] == w_rd_bin[PW-2:0]);
    assign w_accept = wr_en & ~w_full;

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign wr_ptr_bin  = r_wr_ptr;
    assign wr_addr     = r_wr_ptr[PW-2:0];
    assign wr_mem_en   = w_accept;
    assign full        = w_full;
    assign almost_full = (w_level >= AF_THR);
    assign level       = w_level;
    assign overflow    = r_overflow;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at ADDR_W=2, AF_LEVEL=3.
module tb_fifo_wr_ctrl;
    localparam int ADDR_W = 2;
    localparam int PW     = ADDR_W + 1;

    logic              clk_en = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [PW-1:0]     rd_ptr_gray;
    logic [PW-1:0]     wr_ptr_bin;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_mem_en;
    logic              full;
    logic              almost_full;
    logic [PW-1:0]     level;
    logic              overflow;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wr_ctrl #(.ADDR_W(ADDR_W), .AF_LEVEL(3)) dut (
        .clk_en      (clk_en),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_ptr_gray (rd_ptr_gray),
        .wr_ptr_bin  (wr_ptr_bin),
        .wr_addr     (wr_addr),
        .wr_mem_en   (wr_mem_en),
        .full        (full),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow)
    );

    always #5 clk_en = ~clk_en;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk_en);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_ptr_gray = '0;
        #3;
        n_cmp++; if (wr_ptr_bin !== 3'd0) begin n_bad++; $display("FAIL reset_ptr: got %0d want 0", wr_ptr_bin); end
        n_cmp++; if ({full, almost_full, overflow, wr_mem_en} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {full, almost_full, overflow, wr_mem_en}); end
        n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        logic [ADDR_W-1:0] exp_addr;
        logic [PW-1:0]     exp_ptr;
        for (int k = 1; k <= 4; k++) begin
            exp_addr = ADDR_W'(k - 1);
            exp_ptr  = PW'(k);
            wr_en = 1'b1;
            #1;
            n_cmp++; if (wr_mem_en !== 1'b1) begin n_bad++; $display("FAIL fill_mem_en[%0d]: got %b want 1", k, wr_mem_en); end
            n_cmp++; if (wr_addr !== exp_addr) begin n_bad++; $display("FAIL fill_addr[%0d]: got %0d want %0d", k, wr_addr, exp_addr); end
            tick();
            n_cmp++; if (wr_ptr_bin !== exp_ptr) begin n_bad++; $display("FAIL fill_ptr[%0d]: got %0d want %0d", k, wr_ptr_bin, exp_ptr); end
            n_cmp++; if (level !== exp_ptr) begin n_bad++; $display("FAIL fill_level[%0d]: got %0d want %0d", k, level, exp_ptr); end
            n_cmp++; if (almost_full !== (k >= 3)) begin n_bad++; $display("FAIL fill_af[%0d]: got %b want %b", k, almost_full, (k >= 3)); end
            n_cmp++; if (full !== (k == 4)) begin n_bad++; $display("FAIL fill_full[%0d]: got %b want %b", k, full, (k == 4)); end
        end
        wr_en = 1'b0;
        #1;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_no_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        wr_en = 1'b1;
        #1;
        n_cmp++; if (wr_mem_en !== 1'b0) begin n_bad++; $display("FAIL ovf_mem_en: got %b want 0", wr_mem_en); end
        tick();
        wr_en = 1'b0;
        n_cmp++; if (wr_ptr_bin !== 3'd4) begin n_bad++; $display("FAIL ovf_ptr: got %0d want 4", wr_ptr_bin); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    endtask

    task automatic test_release();
        rd_ptr_gray = 3'b001;
        tick();
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL rel_full_e1: got %b want 1", full); end
        n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL rel_level_e1: got %0d want 4", level); end
        tick();
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rel_full_e2: got %b want 0", full); end
        n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL rel_level_e2: got %0d want 3", level); end
        n_cmp++; if (almost_full !== 1'b1) begin n_bad++; $display("FAIL rel_af: got %b want 1", almost_full); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL rel_ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_simultaneous();
        rd_ptr_gray = 3'b011;
        tick();
        n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL sim_level_pre: got %0d want 3", level); end
        wr_en = 1'b1;
        #1;
        n_cmp++; if (wr_mem_en !== 1'b1) begin n_bad++; $display("FAIL sim_mem_en: got %b want 1", wr_mem_en); end
        tick();
        wr_en = 1'b0;
        n_cmp++; if (wr_ptr_bin !== 3'd5) begin n_bad++; $display("FAIL sim_ptr: got %0d want 5", wr_ptr_bin); end
        n_cmp++; if (level !== 3'd3) begin n_bad++; $display("FAIL sim_level_post: got %0d want 3", level); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL sim_full: got %b want 0", full); end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] exp_ptr;
        exp_ptr = 3'd5;
        rd_ptr_gray = to_gray(3'd3);
        tick();
        tick();
        n_cmp++; if (level !== 3'd2) begin n_bad++; $display("FAIL wrap_start_level: got %0d want 2", level); end
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            tick();
            wr_en = 1'b0;
            exp_ptr = exp_ptr + 1'b1;
            rd_ptr_gray = to_gray(exp_ptr - 3'd2);
            tick();
            tick();
            n_cmp++; if (wr_ptr_bin !== exp_ptr) begin n_bad++; $display("FAIL wrap_ptr[%0d]: got %0d want %0d", i, wr_ptr_bin, exp_ptr); end
            n_cmp++; if (level !== 3'd2) begin n_bad++; $display("FAIL wrap_level[%0d]: got %0d want 2", i, level); end
            n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL wrap_full[%0d]: got %b want 0", i, full); end
        end
    endtask

    task automatic test_reset_mid();
        n_cmp++; if (wr_ptr_bin !== 3'd5) begin n_bad++; $display("FAIL rstmid_pre_ptr: got %0d want 5", wr_ptr_bin); end
        #2;
        wr_en = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (wr_ptr_bin !== 3'd0) begin n_bad++; $display("FAIL rstmid_ptr: got %0d want 0", wr_ptr_bin); end
        n_cmp++; if (wr_addr !== 2'd0) begin n_bad++; $display("FAIL rstmid_addr: got %0d want 0", wr_addr); end
        n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rstmid_level: got %0d want 0", level); end
        n_cmp++; if ({full, almost_full, overflow} !== 3'b000) begin n_bad++; $display("FAIL rstmid_flags: got %b want 000", {full, almost_full, overflow}); end
        n_cmp++; if (wr_mem_en !== 1'b1) begin n_bad++; $display("FAIL rstmid_mem_en: got %b want 1", wr_mem_en); end
        wr_en = 1'b0;
        rd_ptr_gray = '0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (wr_ptr_bin !== 3'd0) begin n_bad++; $display("FAIL rstmid_after_ptr: got %0d want 0", wr_ptr_bin); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
